// File: rtl/iwrr_pkg.sv
// Shared defaults and helpers for the IWRR round tracker.
package iwrr_pkg;
  localparam int unsigned IWRR_REQ_NUM_DEF   = 3;
  localparam int unsigned IWRR_WEIGHT_W_DEF  = 2;
  localparam int unsigned IWRR_ROUND_CNT_DEF = 8;

  // LSB position of requester idx inside a packed weight vector.
  // Use it as [w_lsb(idx, w) +: w].
  function automatic int unsigned w_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction
endpackage

// File: rtl/iwrr_level_mask.sv
// Combinational per-level credit mask and last-level detection.
module iwrr_level_mask
  import iwrr_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = IWRR_REQ_NUM_DEF,
  parameter int unsigned P_WEIGHT_W      = IWRR_WEIGHT_W_DEF
) (
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] eff_w_i,
  input  logic [P_WEIGHT_W-1:0]                 level_i,
  output logic [P_REQUESTER_NUM-1:0]            has_credit_o,
  output logic                                  last_lvl_o
);
  // Next level is computed one bit wider so the top level cannot wrap to 0.
  logic [P_WEIGHT_W:0]          lvl_nxt;
  logic [P_REQUESTER_NUM-1:0]   beyond_nxt;

  assign lvl_nxt = {1'b0, level_i} + (P_WEIGHT_W+1)'(1);

  for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_req
    logic [P_WEIGHT_W-1:0] w;
    assign w               = eff_w_i[w_lsb(i, P_WEIGHT_W) +: P_WEIGHT_W];
    assign has_credit_o[i] = (w > level_i);
    assign beyond_nxt[i]   = ({1'b0, w} > lvl_nxt);
  end

  // Last level when no weight reaches past the next level, i.e. max(w) == level+1
  // whenever a level actually closes.
  assign last_lvl_o = ~|beyond_nxt;
endmodule

// File: rtl/iwrr_round_tracker.sv
// IWRR round tracker: interleave level, per-level served mask, round-start
// weight snapshot and the round completion pulse.
// Optional round counter output enabled by defining IWRR_ROUND_CNT_EN.
module iwrr_round_tracker
  import iwrr_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = IWRR_REQ_NUM_DEF,
  parameter int unsigned P_WEIGHT_W      = IWRR_WEIGHT_W_DEF,
  parameter int unsigned P_ROUND_CNT_W   = IWRR_ROUND_CNT_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] req_weight_i,
  input  logic [P_REQUESTER_NUM-1:0]            req_i,
  input  logic [P_REQUESTER_NUM-1:0]            grant_i,
  input  logic                                  grant_hsk_i,
  output logic [P_REQUESTER_NUM-1:0]            eligible_o,
  output logic [P_WEIGHT_W-1:0]                 level_o,
  output logic                                  round_comp_o
`ifdef IWRR_ROUND_CNT_EN
  ,
  output logic [P_ROUND_CNT_W-1:0]              round_cnt_o
`endif
);
  localparam int unsigned WV = P_REQUESTER_NUM * P_WEIGHT_W;

  logic [P_WEIGHT_W-1:0]      level_q, level_d;
  logic [P_REQUESTER_NUM-1:0] served_q, served_d;
  logic [WV-1:0]              weight_q, weight_d;
  logic                       round_comp_q, round_comp_d;

  logic                       round_start;
  logic [WV-1:0]              eff_w;
  logic [P_REQUESTER_NUM-1:0] has_credit, acc, served_n, remain;
  logic                       last_lvl, lvl_close, round_done;

  // Weights are live at round start and frozen once the round is underway.
  assign round_start = (level_q == '0) && (served_q == '0);
  assign eff_w       = round_start ? req_weight_i : weight_q;

  iwrr_level_mask #(
    .P_REQUESTER_NUM (P_REQUESTER_NUM),
    .P_WEIGHT_W      (P_WEIGHT_W)
  ) u_level_mask (
    .eff_w_i      (eff_w),
    .level_i      (level_q),
    .has_credit_o (has_credit),
    .last_lvl_o   (last_lvl)
  );

  assign eligible_o = req_i & has_credit & ~served_q;
  assign acc        = grant_i & eligible_o & {P_REQUESTER_NUM{grant_hsk_i}};
  assign served_n   = served_q | acc;
  // A requester that drops its request no longer holds the level open.
  assign remain     = req_i & has_credit & ~served_n;
  assign lvl_close  = (remain == '0) && (served_n != '0);
  assign round_done = lvl_close && last_lvl;

  // Next-state: snapshot weights, track served set, advance or wrap the level.
  always_comb begin
    weight_d     = weight_q;
    served_d     = served_n;
    level_d      = level_q;
    round_comp_d = 1'b0;
    if (round_start) weight_d = req_weight_i;
    if (lvl_close) begin
      served_d = '0;
      if (last_lvl) begin
        level_d      = '0;
        round_comp_d = 1'b1;
      end else begin
        level_d = level_q + P_WEIGHT_W'(1);
      end
    end
  end

  // State registers; reset drops any round in progress without a pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q      <= '0;
      served_q     <= '0;
      weight_q     <= '0;
      round_comp_q <= 1'b0;
    end else begin
      level_q      <= level_d;
      served_q     <= served_d;
      weight_q     <= weight_d;
      round_comp_q <= round_comp_d;
    end
  end

  assign level_o      = level_q;
  assign round_comp_o = round_comp_q;

`ifdef IWRR_ROUND_CNT_EN
  logic [P_ROUND_CNT_W-1:0] round_cnt_q, round_cnt_d;

  // Completed-round count, stepping in the same cycle the pulse is raised.
  always_comb begin
    round_cnt_d = round_cnt_q;
    if (round_done) round_cnt_d = round_cnt_q + P_ROUND_CNT_W'(1);
  end

  // Round counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) round_cnt_q <= '0;
    else          round_cnt_q <= round_cnt_d;
  end

  assign round_cnt_o = round_cnt_q;
`endif
endmodule

// File: tb/tb_iwrr_round_tracker.sv
// Directed self-checking bench for iwrr_round_tracker (N=3, W=2).
module tb_iwrr_round_tracker;
  localparam int N  = 3;
  localparam int W  = 2;
  localparam int CW = 2;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [N*W-1:0] req_weight_i;
  logic [N-1:0]   req_i, grant_i;
  logic           grant_hsk_i;
  logic [N-1:0]   eligible_o;
  logic [W-1:0]   level_o;
  logic           round_comp_o;
`ifdef IWRR_ROUND_CNT_EN
  logic [CW-1:0]  round_cnt_o;
`endif

  // w2=2, w1=1, w0=3
  localparam logic [N*W-1:0] WGT_A = {2'd2, 2'd1, 2'd3};
  localparam logic [N*W-1:0] WGT_B = {2'd1, 2'd1, 2'd1};

  int n_chk  = 0;
  int n_pass = 0;

  iwrr_round_tracker #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W),
    .P_ROUND_CNT_W   (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_weight_i (req_weight_i),
    .req_i        (req_i),
    .grant_i      (grant_i),
    .grant_hsk_i  (grant_hsk_i),
    .eligible_o   (eligible_o),
    .level_o      (level_o),
    .round_comp_o (round_comp_o)
`ifdef IWRR_ROUND_CNT_EN
    ,
    .round_cnt_o  (round_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // One clock with the given grant/handshake; inputs return idle 1ns after the edge.
  task automatic cyc(input logic [N-1:0] g, input logic hsk);
    grant_i     = g;
    grant_hsk_i = hsk;
    @(posedge clk_i);
    #1;
    grant_i     = '0;
    grant_hsk_i = 1'b0;
  endtask

  task automatic hs(input logic [N-1:0] g);
    cyc(g, 1'b1);
  endtask

  initial begin
    rst_n_i      = 1'b0;
    req_weight_i = WGT_A;
    req_i        = 3'b111;
    grant_i      = '0;
    grant_hsk_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_level", level_o, 0);
    chk("rst_comp", round_comp_o, 0);
    rst_n_i = 1'b1;
    #1;
    chk("rst_elig", eligible_o, 3'b111);

    // Full round: 0,1,2 | 0,2 | 0
    hs(3'b001);
    chk("r1_elig_part", eligible_o, 3'b110);
    hs(3'b010); hs(3'b100);
    chk("r1_lvl1", level_o, 1);
    chk("r1_elig_l1", eligible_o, 3'b101);
    chk("r1_nocomp_l1", round_comp_o, 0);
    hs(3'b001); hs(3'b100);
    chk("r1_lvl2", level_o, 2);
    chk("r1_elig_l2", eligible_o, 3'b001);
    chk("r1_nocomp_l2", round_comp_o, 0);
    hs(3'b001);
    chk("r1_comp", round_comp_o, 1);
    chk("r1_lvl_wrap", level_o, 0);
    cyc('0, 1'b0);
    chk("r1_comp_single", round_comp_o, 0);
    chk("r1_elig_restart", eligible_o, 3'b111);

    // Grant to a non-eligible requester is ignored
    hs(3'b001); hs(3'b010); hs(3'b100);
    hs(3'b010);
    chk("ign_level", level_o, 1);
    chk("ign_elig", eligible_o, 3'b101);
    hs(3'b001);
    chk("ign_elig2", eligible_o, 3'b100);
    hs(3'b100); hs(3'b001);
    chk("ign_comp", round_comp_o, 1);

    // Request drop closes the level without a handshake
    hs(3'b001); hs(3'b010);
    chk("drop_pre", eligible_o, 3'b100);
    req_i = 3'b011;
    #1;
    chk("drop_elig", eligible_o, 3'b000);
    cyc('0, 1'b0);
    chk("drop_level", level_o, 1);
    chk("drop_nocomp", round_comp_o, 0);
    chk("drop_elig_l1", eligible_o, 3'b001);
    req_i = 3'b111;
    hs(3'b001); hs(3'b100); hs(3'b001);
    chk("drop_comp", round_comp_o, 1);

    // Mid-round weight change applies only from the next round
    hs(3'b001); hs(3'b010); hs(3'b100);
    req_weight_i = WGT_B;
    #1;
    chk("wchg_elig_l1", eligible_o, 3'b101);
    hs(3'b001); hs(3'b100);
    chk("wchg_lvl2", level_o, 2);
    hs(3'b001);
    chk("wchg_old_comp", round_comp_o, 1);
    hs(3'b001);
    chk("wchg_b2b_elig", eligible_o, 3'b110);
    hs(3'b010);
    chk("wchg_nocomp", round_comp_o, 0);
    hs(3'b100);
    chk("wchg_new_comp", round_comp_o, 1);
    chk("wchg_new_lvl", level_o, 0);

    // Async reset at level 2
    req_weight_i = WGT_A;
    hs(3'b001); hs(3'b010); hs(3'b100); hs(3'b001); hs(3'b100);
    chk("ar_pre_lvl", level_o, 2);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("ar_lvl", level_o, 0);
    chk("ar_comp", round_comp_o, 0);
    @(posedge clk_i); #1;
    chk("ar_comp_hold", round_comp_o, 0);
    rst_n_i = 1'b1;
    req_weight_i = WGT_B;
    hs(3'b001); hs(3'b010); hs(3'b100);
    chk("ar_reload_comp", round_comp_o, 1);

    // All weights zero: nothing eligible, nothing advances
    req_weight_i = '0;
    cyc('0, 1'b0);
    chk("z_elig", eligible_o, 3'b000);
    hs(3'b111);
    chk("z_level", level_o, 0);
    chk("z_comp", round_comp_o, 0);
    req_weight_i = WGT_B;
    #1;
    chk("z_recover_elig", eligible_o, 3'b111);

`ifdef IWRR_ROUND_CNT_EN
    rst_n_i = 1'b0;
    #1;
    chk("cnt_rst", round_cnt_o, 0);
    rst_n_i = 1'b1;
    for (int r = 0; r < 5; r++) begin
      hs(3'b001); hs(3'b010);
      chk("cnt_hold", round_cnt_o, r % 4);
      hs(3'b100);
      chk("cnt_comp", round_comp_o, 1);
      chk("cnt_val", round_cnt_o, (r + 1) % 4);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
